// File: rtl/classif_sequencer_if.sv
// rtl/classif_sequencer_if.sv - note input, classifier handshake, result and statistics signals of classif_sequencer
interface classif_sequencer_if;
  logic       in_valid;
  logic [3:0] in_nota;
  logic       in_ready;
  logic [3:0] clf_nota;
  logic       clf_ok;
  logic       clf_reset;
  logic       clf_fim;
  logic [1:0] clf_tipo;
  logic       res_valid;
  logic [1:0] res_tipo;
  logic       busy;
  logic       stats_clr;
  logic [7:0] cnt_erro;
  logic [7:0] cnt_adj;
  logic [7:0] cnt_comp;
  logic [7:0] cnt_adv;

  // environment side: offers notes, plays the classifier, reads results
  modport master (
    output in_valid, in_nota, clf_fim, clf_tipo, stats_clr,
    input  in_ready, clf_nota, clf_ok, clf_reset, res_valid, res_tipo, busy,
    input  cnt_erro, cnt_adj, cnt_comp, cnt_adv
  );

  // sequencer side
  modport slave (
    input  in_valid, in_nota, clf_fim, clf_tipo, stats_clr,
    output in_ready, clf_nota, clf_ok, clf_reset, res_valid, res_tipo, busy,
    output cnt_erro, cnt_adj, cnt_comp, cnt_adv
  );
endinterface

// File: rtl/classif_sequencer.sv
// rtl/classif_sequencer.sv - buffers notes and feeds them one at a time to a word classifier; optional counters under CLASSIF_STATS_EN
module classif_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int OK_WIDTH   = 1,
  parameter int SETTLE     = 1
) (
  input logic               clock,
  input logic               reset,
  classif_sequencer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] OK_LAST  = 16'(OK_WIDTH - 1);
  localparam logic [15:0] SET_LAST = 16'(SETTLE - 1);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, WAIT, CHECK, REPORT, DRAIN, CLR} state_t;

  state_t        state;
  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [3:0]    head;
  logic          push;
  logic          pop;
  logic          empty;
  logic          head_term;
  logic          last_term;
  logic [3:0]    nota_q;
  logic          ok_q;
  logic          res_valid_q;
  logic [1:0]    res_tipo_q;
  logic          clr_q;
  logic [15:0]   timer;

  assign empty     = (count == '0);
  assign push      = bus.in_valid && (count != DEPTH_C);
  assign pop       = !empty && (state == IDLE || state == DRAIN);
  assign head      = mem[rd_ptr];
  // 0000 and 1000 both end a word
  assign head_term = (head[2:0] == 3'b000);

  assign bus.in_ready  = (count != DEPTH_C);
  assign bus.clf_nota  = nota_q;
  assign bus.clf_ok    = ok_q;
  assign bus.clf_reset = reset | clr_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_tipo  = res_tipo_q;
  assign bus.busy      = (state != IDLE) || !empty;

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.in_nota;
  end

  // note sequencing FSM with registered classifier strobes and result pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      nota_q      <= 4'b0000;
      ok_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_tipo_q  <= 2'b00;
      clr_q       <= 1'b0;
      last_term   <= 1'b0;
      timer       <= '0;
    end else begin
      res_valid_q <= 1'b0;
      clr_q       <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            nota_q    <= head;
            last_term <= head_term;
            state     <= SETUP;
          end
        end
        SETUP: begin
          ok_q  <= 1'b1;
          timer <= OK_LAST;
          state <= PULSE;
        end
        PULSE: begin
          if (timer == '0) begin
            ok_q  <= 1'b0;
            timer <= SET_LAST;
            state <= WAIT;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        WAIT: begin
          if (timer == '0) state <= CHECK;
          else             timer <= timer - 16'd1;
        end
        CHECK: begin
          if (bus.clf_fim) begin
            res_tipo_q  <= bus.clf_tipo;
            res_valid_q <= 1'b1;
            state       <= REPORT;
          end else begin
            state <= IDLE;
          end
        end
        REPORT: begin
          // classifier finished early: the rest of the word must be skipped
          if (last_term) begin
            clr_q <= 1'b1;
            state <= CLR;
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!empty && head_term) begin
            clr_q <= 1'b1;
            state <= CLR;
          end
        end
        CLR: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CLASSIF_STATS_EN
  logic [7:0] cnt [4];

  // per-type saturating word counters; clear wins over a same-cycle increment
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) cnt[i] <= 8'd0;
    end else if (bus.stats_clr) begin
      for (int i = 0; i < 4; i++) cnt[i] <= 8'd0;
    end else if (res_valid_q && cnt[res_tipo_q] != 8'hFF) begin
      cnt[res_tipo_q] <= cnt[res_tipo_q] + 8'd1;
    end
  end

  assign bus.cnt_erro = cnt[0];
  assign bus.cnt_adj  = cnt[1];
  assign bus.cnt_comp = cnt[2];
  assign bus.cnt_adv  = cnt[3];
`else
  logic unused_stats_clr;
  assign unused_stats_clr = bus.stats_clr;
  assign bus.cnt_erro = 8'd0;
  assign bus.cnt_adj  = 8'd0;
  assign bus.cnt_comp = 8'd0;
  assign bus.cnt_adv  = 8'd0;
`endif
endmodule
